ula_multiciclo: RTL and testbench

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

---
 rtl/ula_pkg.sv | 45 ++++
 rtl/ula_mul_iter.sv | 70 +++++++
 rtl/ula_multiciclo.sv | 231 +++++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ula_pkg                                                      |
// | Description : Shared definitions for the multicycle ALU: opcode encoding,  |
// |               control FSM states and bit positions inside the flag word.   |
// |               flags = {Negative, Overflow, Carry, Zero}.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ula_pkg;

    // Operation select carried on ULAControl; codes 11..15 are undefined and
    // produce a zero result.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLTU = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } ula_op_e;

    // Control FSM. ST_BUSY is only ever entered when the iterative multiplier
    // is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ula_state_e;

    // Bit positions inside the 4-bit flag word.
    localparam int c_flag_z = 0;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 2;
    localparam int c_flag_n = 3;

    // Flag word after reset: result is zero, so only Zero is set.
    localparam logic [3:0] c_flags_rst = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/ula_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ula_mul_iter                                                 |
// | Description : Iterative shift-add unsigned multiplier, one multiplier bit  |
// |               per clock. Operands are captured on start; the full         |
// |               2*WIDTH-bit product is formed over exactly WIDTH steps.      |
// |               Only instantiated when ULA_MUL_EN is defined.                |
// | Ports       : clk, rst_n (async, active low)                               |
// |               start   - load a/b and begin (ignored while running)        |
// |               a, b    - WIDTH-bit operands                                |
// |               done    - high during the final step                        |
// |               product - 2*WIDTH-bit product, valid while done is high     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ula_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                c_cntw = $clog2(WIDTH);
    localparam logic [c_cntw-1:0] c_last = c_cntw'(WIDTH - 1);
    localparam logic [c_cntw-1:0] c_one  = c_cntw'(1);

    logic                 r_busy;
    logic [c_cntw-1:0]    r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    // Partial sum after the current step. Exposing it directly (rather than a
    // registered copy) lets the consumer capture the final product on the same
    // edge that performs the last step, so the unit takes exactly WIDTH cycles.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done      = r_busy && (r_cnt == c_last);
    assign product   = w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start && !r_busy) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + c_one;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ula_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ula_multiciclo                                               |
// | Description : Multicycle ALU with valid/ready handshakes on both sides.    |
// |               Single-cycle ops (ADD, SUB, AND, OR, XOR, SLTU, SLT, SLL,    |
// |               SRL, SRA) complete one cycle after accept. MUL uses an       |
// |               iterative shift-add unit and completes WIDTH+1 cycles after  |
// |               accept. Result and flags are held until out_ready.           |
// | Config      : ULA_MUL_EN - compile in the iterative multiplier. Without   |
// |               it, MUL (10) behaves as an undefined opcode (result 0).      |
// | Ports       : clk, rst_n (async, active low)                               |
// |               in_valid/in_ready   - operation handshake (ready in IDLE)   |
// |               SrcA, SrcB          - operands; SrcB low bits = shift amt   |
// |               ULAControl          - operation select                      |
// |               out_valid/out_ready - result handshake                      |
// |               ULAResult           - registered result                     |
// |               flags               - {Negative, Overflow, Carry, Zero}     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  SrcA,
    input  logic [WIDTH-1:0]  SrcB,
    input  logic [3:0]        ULAControl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ULAResult,
    output logic [3:0]        flags
);

    localparam int c_shw = $clog2(WIDTH);
    localparam int c_msb = WIDTH - 1;

    ula_state_e         r_state;
    ula_state_e         w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               w_load_alu;

    logic [c_shw-1:0]   w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_sra;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_alu_v;
    logic [3:0]         w_alu_flags;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_shamt = SrcB[c_shw-1:0];

    // The extra MSB of the sum is the carry-out; the extra MSB of the
    // unsigned difference is the borrow (set exactly when A < B).
    assign w_sum = {1'b0, SrcA} + {1'b0, SrcB};
    assign w_dif = {1'b0, SrcA} - {1'b0, SrcB};

    // Shifts are done on a WIDTH+1 vector with a guard bit on the side the
    // data leaves, so the guard bit ends up holding the last bit shifted out
    // (and stays 0 for a zero shift amount).
    assign w_shl = {1'b0, SrcA} << w_shamt;
    assign w_shr = {SrcA, 1'b0} >> w_shamt;
    assign w_sra = $unsigned($signed({SrcA, 1'b0}) >>> w_shamt);

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ULAControl)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (SrcA[c_msb] == SrcB[c_msb]) && (w_sum[c_msb] != SrcA[c_msb]);
            end
            OP_SUB: begin
                w_alu_res = w_dif[WIDTH-1:0];
                w_alu_c   = w_dif[WIDTH];
                w_alu_v   = (SrcA[c_msb] != SrcB[c_msb]) && (w_dif[c_msb] != SrcA[c_msb]);
            end
            OP_AND:  w_alu_res = SrcA & SrcB;
            OP_OR:   w_alu_res = SrcA | SrcB;
            OP_XOR:  w_alu_res = SrcA ^ SrcB;
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            OP_SRL: begin
                w_alu_res = w_shr[WIDTH:1];
                w_alu_c   = w_shr[0];
            end
            OP_SRA: begin
                w_alu_res = w_sra[WIDTH:1];
                w_alu_c   = w_sra[0];
            end
            // MUL is handled by the iterative unit when present; otherwise it
            // falls through with the undefined codes and yields zero.
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_alu_flags           = '0;
        w_alu_flags[c_flag_n] = w_alu_res[c_msb];
        w_alu_flags[c_flag_v] = w_alu_v;
        w_alu_flags[c_flag_c] = w_alu_c;
        w_alu_flags[c_flag_z] = (w_alu_res == '0);
    end

`ifdef ULA_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiplier
    // ------------------------------------------------------------------
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic                 w_load_mul;
    logic [2*WIDTH-1:0]   w_mul_product;
    logic [3:0]           w_mul_flags;

    ula_mul_iter #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (SrcA),
        .b       (SrcB),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // Overflow flags any set bit above the low WIDTH bits of the product.
    always_comb begin
        w_mul_flags           = '0;
        w_mul_flags[c_flag_n] = w_mul_product[c_msb];
        w_mul_flags[c_flag_v] = |w_mul_product[2*WIDTH-1:WIDTH];
        w_mul_flags[c_flag_c] = 1'b0;
        w_mul_flags[c_flag_z] = (w_mul_product[WIDTH-1:0] == '0);
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_alu  = 1'b0;
`ifdef ULA_MUL_EN
        w_mul_start = 1'b0;
        w_load_mul  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ULA_MUL_EN
                    if (ULAControl == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_load_alu  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
`else
                    w_load_alu  = 1'b1;
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef ULA_MUL_EN
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_load_mul  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result / flag registers: written only at accept (single-cycle ops) or
    // at multiplier completion, so input changes elsewhere are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= c_flags_rst;
        end else if (w_load_alu) begin
            r_result <= w_alu_res;
            r_flags  <= w_alu_flags;
        end
`ifdef ULA_MUL_EN
        else if (w_load_mul) begin
            r_result <= w_mul_product[WIDTH-1:0];
            r_flags  <= w_mul_flags;
        end
`endif
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign ULAResult = r_result;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ula_multiciclo                                            |
// | Description : Self-checking bench for ula_multiciclo (WIDTH=8). Expected   |
// |               results are queued when an operation is accepted and        |
// |               compared when out_valid is seen. MUL expectations follow    |
// |               ULA_MUL_EN.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ula_multiciclo;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

`ifdef ULA_MUL_EN
    localparam int MUL_LAT = 9;
`else
    localparam int MUL_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] SrcA = 8'h00;
    logic [7:0] SrcB = 8'h00;
    logic [3:0] ULAControl = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] ULAResult;
    logic [3:0] flags;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    ula_multiciclo #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ULAControl (ULAControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ULAResult  (ULAResult),
        .flags      (flags)
    );

    // Reference model, written with integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sbv, full, sh;
        logic [7:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sbv = int'($signed(b));
        sh = int'(b[2:0]);
        full = 0;
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin full = ua + ub; r = full[7:0]; c = (full > 255);
                        v = (sa + sbv > 127) || (sa + sbv < -128); end
            4'd1: begin full = ua - ub; r = full[7:0]; c = (ua < ub);
                        v = (sa - sbv > 127) || (sa - sbv < -128); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (ua < ub) ? 8'd1 : 8'd0;
            4'd6: r = (sa < sbv) ? 8'd1 : 8'd0;
            4'd7: begin full = ua << sh; r = full[7:0]; c = (sh != 0) && full[8]; end
            4'd8: begin r = 8'(ua >> sh); c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
            4'd9: begin r = 8'(sa >>> sh); c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
`ifdef ULA_MUL_EN
            4'd10: begin full = ua * ub; r = full[7:0]; v = (full > 255); end
`endif
            default: r = 8'h00;
        endcase
        return {r, r[7], v, c, (r == 8'h00)};
    endfunction

    // Present one operation (called at posedge+1 with DUT idle) and queue
    // its expectation; operands are scrambled right after the accept edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready op=%0d in_ready=%b expected 1", op, in_ready);
        end
        in_valid   = 1'b1;
        ULAControl = op;
        SrcA       = a;
        SrcB       = b;
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        SrcA       = 8'($urandom);
        SrcB       = 8'($urandom);
        ULAControl = 4'($urandom);
    endtask

    // Wait for out_valid, check latency and data against the queue, hold
    // backpressure for 'hold' cycles while poking in_valid, then release.
    task automatic collect(input string name, input int lat_exp, input int hold);
        int   lat;
        exp_t e;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_ready in_ready=%b expected 0 cycle=%0d", name, in_ready, lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard queue empty when output expected", name);
            return;
        end
        e = sbq.pop_front();
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%b expected 1 within %0d cycles", name, out_valid, lat);
            return;
        end
        checks++;
        if (lat !== lat_exp) begin
            failures++;
            $display("FAIL %s_latency got=%0d expected=%0d", name, lat, lat_exp);
        end
        checks++;
        if (ULAResult !== e.res) begin
            failures++;
            $display("FAIL %s_result got=%h expected=%h", name, ULAResult, e.res);
        end
        checks++;
        if (flags !== e.flg) begin
            failures++;
            $display("FAIL %s_flags got=%b expected=%b", name, flags, e.flg);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            SrcA       = 8'($urandom);
            SrcB       = 8'($urandom);
            ULAControl = 4'($urandom_range(0, 9));
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ULAResult !== e.res || flags !== e.flg) begin
                failures++;
                $display("FAIL %s_hold cycle=%0d got valid=%b ready=%b res=%h flg=%b expected valid=1 ready=0 res=%h flg=%b",
                         name, i, out_valid, in_ready, ULAResult, flags, e.res, e.flg);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_release got valid=%b ready=%b expected valid=0 ready=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || ULAResult !== 8'h00 || flags !== 4'b0001) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b res=%h flg=%b expected valid=0 res=00 flg=0001",
                     out_valid, ULAResult, flags);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        send(4'd0, 8'hFF, 8'h01, {8'h00, 4'b0011});
        collect("add_ff_01", 1, 0);
        send(4'd0, 8'h7F, 8'h01, {8'h80, 4'b1100});
        collect("add_7f_01", 1, 0);
    endtask

    task automatic test_sub_slt();
        send(4'd1, 8'h80, 8'h01, {8'h7F, 4'b0100});
        collect("sub_80_01", 1, 0);
        send(4'd1, 8'h01, 8'h02, {8'hFF, 4'b1010});
        collect("sub_01_02", 1, 0);
        send(4'd6, 8'hFF, 8'h01, {8'h01, 4'b0000});
        collect("slt", 1, 0);
        send(4'd5, 8'hFF, 8'h01, {8'h00, 4'b0001});
        collect("sltu", 1, 0);
    endtask

    task automatic test_shifts();
        send(4'd9, 8'h90, 8'h03, {8'hF2, 4'b1000});
        collect("sra_90_3", 1, 0);
        send(4'd7, 8'h81, 8'h01, {8'h02, 4'b0010});
        collect("sll_81_1", 1, 0);
        send(4'd7, 8'h81, 8'hF9, {8'h02, 4'b0010});
        collect("sll_hi_bits", 1, 0);
        send(4'd8, 8'h81, 8'h00, {8'h81, 4'b1000});
        collect("srl_shift0", 1, 0);
        send(4'd8, 8'h81, 8'h01, {8'h40, 4'b0010});
        collect("srl_81_1", 1, 0);
    endtask

    task automatic test_mul();
`ifdef ULA_MUL_EN
        send(4'd10, 8'h0D, 8'h0B, {8'h8F, 4'b1000});
        collect("mul_0d_0b", MUL_LAT, 0);
        send(4'd10, 8'h10, 8'h10, {8'h00, 4'b0101});
        collect("mul_10_10", MUL_LAT, 0);
`else
        send(4'd10, 8'h0D, 8'h0B, {8'h00, 4'b0001});
        collect("mul_0d_0b", MUL_LAT, 0);
        send(4'd10, 8'h10, 8'h10, {8'h00, 4'b0001});
        collect("mul_10_10", MUL_LAT, 0);
`endif
        send(4'd13, 8'h12, 8'h34, {8'h00, 4'b0001});
        collect("undef_op", 1, 0);
    endtask

    task automatic test_backpressure();
        send(4'd0, 8'h12, 8'h34, {8'h46, 4'b0000});
        collect("bp_add", 1, 5);
        send(4'd4, 8'hF0, 8'h3C, {8'hCC, 4'b1000});
        collect("bp_xor", 1, 2);
    endtask

    task automatic test_reset_mid_mul();
        send(4'd10, 8'h0D, 8'h0B, {8'h00, 4'b0000});
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ULAResult !== 8'h00 || flags !== 4'b0001) begin
            failures++;
            $display("FAIL midmul_reset got valid=%b res=%h flg=%b expected valid=0 res=00 flg=0001",
                     out_valid, ULAResult, flags);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL midmul_aborted cycle=%0d got valid=%b ready=%b expected valid=0 ready=1",
                         i, out_valid, in_ready);
            end
        end
        send(4'd0, 8'h03, 8'h04, {8'h07, 4'b0000});
        collect("post_reset_add", 1, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            send(op, a, b, model(op, a, b));
            collect("random", (op == 4'd10) ? MUL_LAT : 1, i % 3);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_shifts();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
